register_file_bist_ctrl: RTL

- March C- BIST sequencer for the 2r/1w asymmetric register-file test wrapper.
- Drives BIST, CSN_T, WEN_T, A_T, D_T and BE_T, and checks Q_T against expected data.
- Reports pass/fail, the first failing address and a mismatch count to the test/config logic.
- One instance per register file; sits between the SoC test controller and the wrapper's BIST pins.

---
 rtl/register_file_bist_pkg.sv | 34 +++
 rtl/register_file_bist_cmp.sv | 102 ++++++++++
 rtl/register_file_bist_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/register_file_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_bist_pkg
//  Description : March C- element tables and FSM state type for the
//                register-file BIST sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package register_file_bist_pkg;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } march_elem_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    // One bit per element, indexed by march_elem_e.
    localparam logic [5:0] c_elem_down   = 6'b011000;  // descending address order
    localparam logic [5:0] c_elem_two_op = 6'b011110;  // read then write at each address
    localparam logic [5:0] c_elem_has_rd = 6'b111110;  // first op of the element is a read
    localparam logic [5:0] c_elem_rd_pol = 6'b010100;  // expected read data is ~background
    localparam logic [5:0] c_elem_wr_pol = 6'b001010;  // written data is ~background

endpackage : register_file_bist_pkg
`default_nettype wire

// File: rtl/register_file_bist_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_bist_cmp
//  Description : Read-latency compare pipe with sticky fail, first-failure
//                capture and saturating mismatch counter.
//  Revision    : 1.0  initial release
// ============================================================================
module register_file_bist_cmp #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  flush,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_exp,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_rdata,
    output logic [CNT_WIDTH-1:0]  fail_count
);

    logic                  w_tap_vld;
    logic [ADDR_WIDTH-1:0] w_tap_addr;
    logic [DATA_WIDTH-1:0] w_tap_exp;
    logic                  w_mismatch;

    logic                  r_fail;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_rdata;
    logic [CNT_WIDTH-1:0]  r_fail_count;

    generate
        if (READ_LATENCY == 0) begin : g_no_pipe
            assign w_tap_vld  = rd_valid;
            assign w_tap_addr = rd_addr;
            assign w_tap_exp  = rd_exp;
        end else begin : g_pipe
            logic [READ_LATENCY-1:0]                 r_vld;
            logic [READ_LATENCY-1:0][ADDR_WIDTH-1:0] r_adr;
            logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] r_exp;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= '0;
                    r_adr <= '0;
                    r_exp <= '0;
                end else begin
                    r_vld[0] <= rd_valid & ~flush;
                    r_adr[0] <= rd_addr;
                    r_exp[0] <= rd_exp;
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        r_vld[i] <= r_vld[i-1] & ~flush;
                        r_adr[i] <= r_adr[i-1];
                        r_exp[i] <= r_exp[i-1];
                    end
                end
            end

            assign w_tap_vld  = r_vld[READ_LATENCY-1];
            assign w_tap_addr = r_adr[READ_LATENCY-1];
            assign w_tap_exp  = r_exp[READ_LATENCY-1];
        end
    endgenerate

    assign w_mismatch = w_tap_vld && (q != w_tap_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_rdata <= '0;
            r_fail_count <= '0;
        end else if (clear) begin
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_rdata <= '0;
            r_fail_count <= '0;
        end else if (w_mismatch && !flush) begin
            r_fail <= 1'b1;
            if (!r_fail) begin
                r_fail_addr  <= w_tap_addr;
                r_fail_rdata <= q;
            end
            if (r_fail_count != '1) begin
                r_fail_count <= r_fail_count + 1'b1;
            end
        end
    end

    assign fail       = r_fail;
    assign fail_addr  = r_fail_addr;
    assign fail_rdata = r_fail_rdata;
    assign fail_count = r_fail_count;

endmodule : register_file_bist_cmp
`default_nettype wire

// File: rtl/register_file_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_bist_ctrl
//  Description : March C- BIST sequencer driving the register-file wrapper
//                test pins and reporting pass/fail status.
//  Revision    : 1.0  initial release
// ============================================================================
module register_file_bist_ctrl
    import register_file_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 5,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    NUM_BYTE     = DATA_WIDTH / 8,
    parameter int                    NUM_WORDS    = 2 ** ADDR_WIDTH,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND   = '0,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_rdata,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  BIST,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    output logic [NUM_BYTE-1:0]   BE_T,
    input  logic [DATA_WIDTH-1:0] Q_T
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr  = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam int                    c_drn_w      = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam logic [c_drn_w-1:0]    c_drain_init = c_drn_w'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    bist_state_e           r_state, w_state_nxt;
    march_elem_e           r_elem, w_adv_elem, w_ptr_elem;
    logic [ADDR_WIDTH-1:0] r_addr, w_adv_addr, w_ptr_addr;
    logic                  r_phase, w_adv_phase, w_ptr_phase;
    logic [c_drn_w-1:0]    r_drain_cnt, w_drain_nxt;

    logic                  w_down, w_two_op, w_at_end, w_last_op;
    logic                  w_issue, w_clear, w_flush, w_active_nxt;
    logic                  w_op_rd;
    logic [DATA_WIDTH-1:0] w_op_data;

    logic                  r_busy, r_done, r_bist, r_csn, r_wen;
    logic [ADDR_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_d, r_exp;
    logic [NUM_BYTE-1:0]   r_be;

    // Sequence pointer (elem, addr, phase) names the op currently on the bus.
    always_comb begin
        w_down      = c_elem_down[r_elem];
        w_two_op    = c_elem_two_op[r_elem];
        w_at_end    = w_down ? (r_addr == '0) : (r_addr == c_last_addr);
        w_last_op   = (r_elem == E5) && w_at_end;
        w_adv_elem  = r_elem;
        w_adv_addr  = r_addr;
        w_adv_phase = 1'b0;
        if (w_two_op && !r_phase) begin
            w_adv_phase = 1'b1;
        end else if (!w_at_end) begin
            w_adv_addr = w_down ? r_addr - 1'b1 : r_addr + 1'b1;
        end else if (r_elem != E5) begin
            w_adv_elem = march_elem_e'(r_elem + 3'd1);
            w_adv_addr = c_elem_down[w_adv_elem] ? c_last_addr : '0;
        end

        if (r_state == RUN) begin
            w_ptr_elem  = w_adv_elem;
            w_ptr_addr  = w_adv_addr;
            w_ptr_phase = w_adv_phase;
        end else begin
            w_ptr_elem  = E0;
            w_ptr_addr  = '0;
            w_ptr_phase = 1'b0;
        end

        w_op_rd   = c_elem_has_rd[w_ptr_elem] && !w_ptr_phase;
        w_op_data = (w_op_rd ? c_elem_rd_pol[w_ptr_elem] : c_elem_wr_pol[w_ptr_elem])
                    ? ~BACKGROUND : BACKGROUND;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_issue     = 1'b0;
        w_clear     = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_issue     = 1'b1;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_flush     = 1'b1;
                end else if (w_last_op) begin
                    w_state_nxt = (READ_LATENCY == 0) ? DONE : DRAIN;
                    w_drain_nxt = c_drain_init;
                end else begin
                    w_issue = 1'b1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_flush     = 1'b1;
                end else if (r_drain_cnt == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_drain_nxt = r_drain_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_active_nxt = (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_elem      <= E0;
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bist      <= 1'b0;
            r_csn       <= 1'b1;
            r_wen       <= 1'b1;
            r_a         <= '0;
            r_d         <= '0;
            r_be        <= '0;
            r_exp       <= '0;
        end else begin
            r_drain_cnt <= w_drain_nxt;
            if (w_issue) begin
                r_elem  <= w_ptr_elem;
                r_addr  <= w_ptr_addr;
                r_phase <= w_ptr_phase;
            end
            r_busy <= w_active_nxt;
            r_bist <= w_active_nxt;
            r_done <= (w_state_nxt == DONE);
            r_csn  <= ~w_issue;
            r_wen  <= ~w_issue | w_op_rd;
            r_a    <= w_issue ? w_ptr_addr : '0;
            r_d    <= (w_issue && !w_op_rd) ? w_op_data : '0;
            r_be   <= w_issue ? '1 : '0;
            r_exp  <= w_op_data;
        end
    end

    register_file_bist_cmp #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_clear),
        .flush      (w_flush | w_clear),
        .rd_valid   (~r_csn & r_wen),
        .rd_addr    (r_a),
        .rd_exp     (r_exp),
        .q          (Q_T),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_rdata (fail_rdata),
        .fail_count (fail_count)
    );

    assign busy  = r_busy;
    assign done  = r_done;
    assign BIST  = r_bist;
    assign CSN_T = r_csn;
    assign WEN_T = r_wen;
    assign A_T   = r_a;
    assign D_T   = r_d;
    assign BE_T  = r_be;

endmodule : register_file_bist_ctrl
`default_nettype wire
